// File: rtl/sqrt_f32_scheduler_pkg.sv
// Shared constants, FSM encoding and f32 special-operand classification for the sqrt scheduler.
// Latency: n/a (pure combinational helpers).
// Backpressure: n/a.
package sqrt_pkg;

    localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] F32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] F32_ZERO    = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        BYPASS = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic        is_special;
        logic [31:0] result;
    } f32_class_t;

    // Rule order matters: zero/denormal checks precede the sign check so -0 survives.
    function automatic f32_class_t f32_classify(input logic [31:0] a);
        f32_class_t c;
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        s = a[31];
        e = a[30:23];
        m = a[22:0];
        c.is_special = 1'b1;
        c.result     = F32_QNAN;
        if (e == 8'd0 && m == 23'd0)
            c.result = a;
        else if (e == 8'd0)
            c.result = F32_ZERO;
        else if (e == 8'hFF && m != 23'd0)
            c.result = F32_QNAN;
        else if (s)
            c.result = F32_QNAN;
        else if (e == 8'hFF)
            c.result = F32_POS_INF;
        else
            c.is_special = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/sqrt_f32_scheduler_if.sv
// Request, result and engine-side signal bundle of the sqrt scheduler.
// Latency: n/a. Backpressure: in_ready / out_ready valid-ready pairs.
// slave = scheduler side, master = PE/engine environment side.
interface sqrt_f32_scheduler_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sqrt;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             eng_rst;
    logic [31:0]      eng_a;
    logic             eng_rdy;
    logic [31:0]      eng_sqrt;

    modport slave (
        input  in_valid, in_a, in_tag, out_ready, eng_rdy, eng_sqrt,
        output in_ready, out_valid, out_sqrt, out_tag, out_err, eng_rst, eng_a
    );

    modport master (
        output in_valid, in_a, in_tag, out_ready, eng_rdy, eng_sqrt,
        input  in_ready, out_valid, out_sqrt, out_tag, out_err, eng_rst, eng_a
    );
endinterface

// File: rtl/sqrt_f32_scheduler_sync_fifo_tagged.sv
// Synchronous FIFO holding {operand, tag} requests; head is visible without a pop (fall-through).
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; full/count exported.
module sync_fifo_tagged #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read of stale entries.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sqrt_f32_scheduler.sv
// Front end for the iterative f32 sqrt engine: queues requests, bypasses IEEE specials, sequences eng_rst/eng_rdy.
// Latency: 2 cycles pop-to-result for specials, 1 + RST_CYCLES + engine + 1 for engine ops; one op in flight.
// Backpressure: in_ready drops when the FIFO is full; no pop while a result waits on out_ready. SQRT_TIMEOUT_EN adds a RUN watchdog.
module sqrt_f32_scheduler
    import sqrt_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    sqrt_f32_scheduler_if.slave   bus
);
    localparam int FW  = 32 + TAG_W;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("sqrt_f32_scheduler: illegal parameter set");
    end

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [FW-1:0]    fifo_head;
    logic [31:0]      head_a;
    logic [TAG_W-1:0] head_tag;
    f32_class_t       head_cls;

    state_t           state,     state_nx;
    logic [RCW-1:0]   rst_cnt,   rst_cnt_nx;
    logic [31:0]      op_res,    op_res_nx;
    logic [TAG_W-1:0] op_tag,    op_tag_nx;
    logic             eng_rst_q, eng_rst_nx;
    logic [31:0]      eng_a_q,   eng_a_nx;
    logic [31:0]      res_sqrt,  res_sqrt_nx;
    logic [TAG_W-1:0] res_tag,   res_tag_nx;

    assign bus.in_ready = ~rst & (fifo_cnt != CW'(DEPTH));
    assign fifo_push    = bus.in_valid & bus.in_ready & ~fifo_full;

    sync_fifo_tagged #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({bus.in_a, bus.in_tag}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign {head_a, head_tag} = fifo_head;
    assign head_cls           = f32_classify(head_a);

`ifdef SQRT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          res_err, res_err_nx;

    // Counts cycles spent in RUN; restarts from zero on every RUN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == RUN)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            res_err <= 1'b0;
        else
            res_err <= res_err_nx;
    end

    assign bus.out_err = res_err;
`else
    assign bus.out_err = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        rst_cnt_nx  = rst_cnt;
        op_res_nx   = op_res;
        op_tag_nx   = op_tag;
        eng_rst_nx  = eng_rst_q;
        eng_a_nx    = eng_a_q;
        res_sqrt_nx = res_sqrt;
        res_tag_nx  = res_tag;
        fifo_pop    = 1'b0;
`ifdef SQRT_TIMEOUT_EN
        res_err_nx  = res_err;
`endif
        case (state)
            IDLE: begin
                eng_rst_nx = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    op_res_nx = head_cls.result;
                    op_tag_nx = head_tag;
                    if (head_cls.is_special) begin
                        state_nx = BYPASS;
                    end else begin
                        eng_a_nx   = head_a;
                        rst_cnt_nx = RCW'(RST_CYCLES - 1);
                        state_nx   = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (rst_cnt == '0) begin
                    eng_rst_nx = 1'b0;
                    state_nx   = RUN;
                end else begin
                    rst_cnt_nx = rst_cnt - 1'b1;
                end
            end
            RUN: begin
                if (bus.eng_rdy) begin
                    res_sqrt_nx = bus.eng_sqrt;
                    res_tag_nx  = op_tag;
                    eng_rst_nx  = 1'b1;
                    state_nx    = DONE;
`ifdef SQRT_TIMEOUT_EN
                    res_err_nx  = 1'b0;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_sqrt_nx = F32_QNAN;
                    res_tag_nx  = op_tag;
                    res_err_nx  = 1'b1;
                    eng_rst_nx  = 1'b1;
                    state_nx    = DONE;
`endif
                end
            end
            BYPASS: begin
                res_sqrt_nx = op_res;
                res_tag_nx  = op_tag;
`ifdef SQRT_TIMEOUT_EN
                res_err_nx  = 1'b0;
`endif
                state_nx    = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: begin
                eng_rst_nx = 1'b1;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            op_res    <= '0;
            op_tag    <= '0;
            eng_rst_q <= 1'b1;
            eng_a_q   <= '0;
            res_sqrt  <= '0;
            res_tag   <= '0;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            op_res    <= op_res_nx;
            op_tag    <= op_tag_nx;
            eng_rst_q <= eng_rst_nx;
            eng_a_q   <= eng_a_nx;
            res_sqrt  <= res_sqrt_nx;
            res_tag   <= res_tag_nx;
        end
    end

    assign bus.out_valid = (state == DONE);
    assign bus.out_sqrt  = res_sqrt;
    assign bus.out_tag   = res_tag;
    assign bus.eng_rst   = eng_rst_q;
    assign bus.eng_a     = eng_a_q;

endmodule

// File: tb/tb_sqrt_f32_scheduler.sv
// Directed bench for sqrt_f32_scheduler with a behavioural engine (fixed latency, lookup-table results).
// Define SQRT_TIMEOUT_EN to also exercise the watchdog path (TIMEOUT_CYCLES=16).
module tb_sqrt_f32_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqrt_f32_scheduler_if #(.TAG_W(4)) bus ();

    sqrt_f32_scheduler #(
        .DEPTH          (4),
        .TAG_W          (4),
        .RST_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int eng_lat = 4;
    bit eng_hang = 1'b0;
    int eng_cnt;
    int rst_low_cnt = 0;

    function automatic logic [31:0] eng_lookup(input logic [31:0] a);
        case (a)
            32'h3F80_0000: return 32'h3F80_0000;   // 1  -> 1
            32'h4080_0000: return 32'h4000_0000;   // 4  -> 2
            32'h4110_0000: return 32'h4040_0000;   // 9  -> 3
            32'h4180_0000: return 32'h4080_0000;   // 16 -> 4
            32'h41C8_0000: return 32'h40A0_0000;   // 25 -> 5
            32'h4210_0000: return 32'h40C0_0000;   // 36 -> 6
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Engine model: restarts on eng_rst, raises eng_rdy eng_lat cycles after release.
    always @(posedge clk) begin
        if (bus.eng_rst !== 1'b0) begin
            eng_cnt      <= 0;
            bus.eng_rdy  <= 1'b0;
            bus.eng_sqrt <= 32'h0;
        end else if (!eng_hang) begin
            if (eng_cnt == eng_lat) begin
                bus.eng_rdy  <= 1'b1;
                bus.eng_sqrt <= eng_lookup(bus.eng_a);
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    always @(negedge clk)
        if (bus.eng_rst === 1'b0) rst_low_cnt++;

    task automatic push(input logic [31:0] a, input logic [3:0] t, input int limit, output bit acc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_tag   = t;
        acc          = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (bus.in_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input int limit, output bit got, output logic [31:0] s,
                              output logic [3:0] t, output logic e);
        @(negedge clk);
        bus.out_ready = 1'b1;
        got = 1'b0;
        s = 'x; t = 'x; e = 'x;
        for (int k = 0; k < limit; k++) begin
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
                s = bus.out_sqrt; t = bus.out_tag; e = bus.out_err;
                break;
            end
            @(negedge clk);
        end
        if (got) @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_sqrt !== 32'h0) begin errors++; $display("FAIL rst_out_sqrt got=%h exp=0", bus.out_sqrt); end
        checks++; if (bus.out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag got=%h exp=0", bus.out_tag); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got=%b exp=0", bus.out_err); end
        checks++; if (bus.eng_rst !== 1'b1) begin errors++; $display("FAIL rst_eng_rst got=%b exp=1", bus.eng_rst); end
        checks++; if (bus.eng_a !== 32'h0) begin errors++; $display("FAIL rst_eng_a got=%h exp=0", bus.eng_a); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_engine_op();
        bit acc, got; logic [31:0] s; logic [3:0] t; logic e;
        eng_lat = 20;
        push(32'h4080_0000, 4'd3, 20, acc);
        checks++; if (!acc) begin errors++; $display("FAIL eng_push accepted=%b exp=1", acc); end
        @(posedge clk); #1;
        checks++; if (bus.eng_rst !== 1'b1 || bus.eng_a !== 32'h4080_0000) begin
            errors++; $display("FAIL launch_c1 eng_rst=%b eng_a=%h exp 1/40800000", bus.eng_rst, bus.eng_a); end
        @(posedge clk); #1;
        checks++; if (bus.eng_rst !== 1'b1) begin errors++; $display("FAIL launch_c2 eng_rst=%b exp=1", bus.eng_rst); end
        @(posedge clk); #1;
        checks++; if (bus.eng_rst !== 1'b0) begin errors++; $display("FAIL run_entry eng_rst=%b exp=0", bus.eng_rst); end
        get_result(100, got, s, t, e);
        checks++; if (!got || s !== 32'h4000_0000 || t !== 4'd3 || e !== 1'b0) begin
            errors++; $display("FAIL eng_result got=%b sqrt=%h tag=%h err=%b exp 40000000/3/0", got, s, t, e); end
        checks++; if (bus.eng_rst !== 1'b1) begin errors++; $display("FAIL eng_rst_after_done got=%b exp=1", bus.eng_rst); end
    endtask

    task automatic test_special();
        logic [31:0] va [7] = '{32'hC080_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0001,
                                32'h7F80_0001, 32'hFF80_0000, 32'h0000_0000};
        logic [31:0] vr [7] = '{32'h7FC0_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000,
                                32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000};
        bit acc, got; logic [31:0] s; logic [3:0] t; logic e;
        int low0;
        low0 = rst_low_cnt;
        for (int i = 0; i < 3; i++) push(va[i], 4'(i + 1), 20, acc);
        for (int i = 0; i < 7; i++) begin
            if (i >= 3) push(va[i], 4'(i + 1), 20, acc);
            get_result(50, got, s, t, e);
            checks++; if (!got || s !== vr[i] || t !== 4'(i + 1) || e !== 1'b0) begin
                errors++; $display("FAIL special_%0d got=%b sqrt=%h tag=%h err=%b exp %h/%h/0", i, got, s, t, e, vr[i], 4'(i + 1)); end
        end
        checks++; if (rst_low_cnt != low0) begin
            errors++; $display("FAIL special_eng_rst_low cycles_low=%0d exp=0", rst_low_cnt - low0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6] = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000, 32'h41C8_0000, 32'h4210_0000};
        logic [31:0] vr [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        bit acc, got; logic [31:0] s; logic [3:0] t; logic e;
        eng_lat = 4;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(va[i], 4'(i), 30, acc);
            checks++; if (acc !== (i < 5)) begin
                errors++; $display("FAIL b2b_accept_%0d got=%b exp=%b", i, acc, (i < 5)); end
        end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got=%b exp=0", bus.in_ready); end
        for (int i = 0; i < 5; i++) begin
            get_result(60, got, s, t, e);
            checks++; if (!got || s !== vr[i] || t !== 4'(i) || e !== 1'b0) begin
                errors++; $display("FAIL b2b_result_%0d got=%b sqrt=%h tag=%h err=%b exp %h/%h/0", i, got, s, t, e, vr[i], 4'(i)); end
        end
    endtask

    task automatic test_reset_mid_op();
        bit acc, got; logic [31:0] s; logic [3:0] t; logic e;
        eng_lat = 20;
        push(32'h4110_0000, 4'd1, 20, acc);
        push(32'h3F80_0000, 4'd2, 20, acc);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.eng_rst === 1'b0) break;
        end
        checks++; if (bus.eng_rst !== 1'b0) begin errors++; $display("FAIL rmid_reach_run eng_rst=%b exp=0", bus.eng_rst); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.eng_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_async out_valid=%b eng_rst=%b in_ready=%b exp 0/1/0", bus.out_valid, bus.eng_rst, bus.in_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_post in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
        eng_lat = 4;
        push(32'h4180_0000, 4'd5, 20, acc);
        get_result(60, got, s, t, e);
        checks++; if (!got || s !== 32'h4080_0000 || t !== 4'd5 || e !== 1'b0) begin
            errors++; $display("FAIL rmid_new_req got=%b sqrt=%h tag=%h err=%b exp 40800000/5/0", got, s, t, e); end
        bus.out_ready = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_fifo_flushed out_valid=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

`ifdef SQRT_TIMEOUT_EN
    task automatic test_timeout();
        bit acc, got; logic [31:0] s; logic [3:0] t; logic e;
        int k;
        eng_hang = 1'b1;
        push(32'h4080_0000, 4'd7, 20, acc);
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (bus.eng_rst === 1'b0) break;
        end
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k != 16) begin errors++; $display("FAIL tmo_run_cycles got=%0d exp=16", k); end
        checks++; if (bus.eng_rst !== 1'b1) begin errors++; $display("FAIL tmo_eng_rst got=%b exp=1", bus.eng_rst); end
        get_result(10, got, s, t, e);
        checks++; if (!got || s !== 32'h7FC0_0000 || t !== 4'd7 || e !== 1'b1) begin
            errors++; $display("FAIL tmo_result got=%b sqrt=%h tag=%h err=%b exp 7fc00000/7/1", got, s, t, e); end
        eng_hang = 1'b0;
        push(32'h4180_0000, 4'd8, 20, acc);
        get_result(60, got, s, t, e);
        checks++; if (!got || s !== 32'h4080_0000 || t !== 4'd8 || e !== 1'b0) begin
            errors++; $display("FAIL tmo_next got=%b sqrt=%h tag=%h err=%b exp 40800000/8/0", got, s, t, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_engine_op();
        test_special();
        test_back_to_back();
        test_reset_mid_op();
`ifdef SQRT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sqrt_f32_scheduler.md
Name: sqrt_f32_scheduler

Overview:
- Front-end stage placed directly upstream of the iterative f32 square-root engine. The engine is started by its own reset and signals completion on `rdy`.
- Accepts a stream of f32 operands with a valid/ready handshake and buffers them in a small FIFO.
- Resolves IEEE special cases locally. Launches the engine only for normal positive operands, using the engine's reset-pulse/rdy protocol.
- Returns results, each with its tag, on a valid/ready output port. This lets PE datapaths issue back-to-back sqrt requests without handling engine sequencing themselves.

Parameters:
- DEPTH, 4, input FIFO entries; power of 2, ≥2.
- TAG_W, 4, width of the caller tag carried with each request.
- RST_CYCLES, 2, cycles eng_rst is held high per launch; ≥1.
- TIMEOUT_CYCLES, 1024, watchdog limit while waiting on eng_rdy (used only with SQRT_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  FIFO not full
- in_a  in  32  f32 operand
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sqrt  out  32  f32 result
- out_tag  out  TAG_W  tag of result
- out_err  out  1  result produced by watchdog, not engine
- eng_rst  out  1  engine reset/start, active high
- eng_a  out  32  engine operand
- eng_rdy  in  1  engine result valid
- eng_sqrt  in  32  engine result

Behaviour:
- Reset values: in_ready=0 during rst, then 1; out_valid=0; out_sqrt=0; out_tag=0; out_err=0; eng_rst=1; eng_a=0; FIFO empty; state IDLE.
- Push: occurs when in_valid && in_ready. A simultaneous push and pop when full is not allowed: in_ready depends only on the count and is 0 when count==DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the op register and classify it.
    - Special operand → BYPASS.
    - Otherwise → LAUNCH, with eng_a=op and eng_rst=1.
    - eng_rst stays 1 throughout IDLE.
  - LAUNCH: hold eng_rst=1 for RST_CYCLES cycles, counted by a down-counter, then drive eng_rst=0 → RUN. eng_a is stable from LAUNCH through RUN.
  - RUN: wait for eng_rdy=1.
    - Capture {eng_sqrt, tag} into the output register with out_err=0.
    - Set eng_rst=1 in the same edge → DONE.
    - eng_rdy while in LAUNCH or IDLE is ignored.
  - BYPASS: load the output register with the special result (one cycle) → DONE.
  - DONE: out_valid=1 until out_valid && out_ready, then → IDLE.
- Result latency: minimum 1 (pop) + 1 (BYPASS) cycles for special operands. For engine operands it is 1 + RST_CYCLES + engine latency + 1.
- Output register is single-entry. The FSM does not pop while out_valid=1.
- Classification, with s=a[31], e=a[30:23], m=a[22:0]:
  - e==0, m==0 → result = a (±0 preserved).
  - e==0, m!=0 (denormal) → 0x00000000 (flush to zero).
  - e==255, m!=0 (NaN) → 0x7FC00000.
  - s==1, any other value → 0x7FC00000.
  - s==0, e==255, m==0 → 0x7F800000.
  - All other operands go to the engine.
- Ordering: results leave in request order. There is exactly one operation in flight.
- Reset mid-operation: asynchronous reset returns to IDLE, drops the in-flight operation and FIFO contents, and drives eng_rst=1 immediately.

Optional Feature:
- Macro: SQRT_TIMEOUT_EN.
- Defined: a counter runs in RUN. At TIMEOUT_CYCLES without eng_rdy, the block loads out_sqrt=0x7FC00000 and out_err=1 with the op's tag, sets eng_rst=1, and goes → DONE.
- Not defined: no counter is built, RUN waits indefinitely, and out_err is tied to 0.

Decomposition:
- Package sqrt_pkg holds:
  - F32_QNAN=32'h7FC00000, F32_POS_INF=32'h7F800000, F32_ZERO.
  - 3-bit state encoding: IDLE, LAUNCH, RUN, BYPASS, DONE.
  - A classification function returning {is_special, special_result}.
- One sub-module, sync_fifo_tagged: depth DEPTH, width 32+TAG_W, async active-high reset, with full/empty/count outputs.

Test Plan:
- Push 0x40800000 (4.0), tag 3; engine model returns 0x40000000 after 20 cycles → out_sqrt=0x40000000, out_tag=3, out_err=0; eng_rst is high for exactly 2 cycles before the run.
- Push 0xC0800000, then 0x80000000, then 0x7F800000 → results 0x7FC00000, 0x80000000, 0x7F800000 in order; eng_rst never deasserts.
- DEPTH=4, out_ready=0, push 6 normal operands → in_ready=0 once 4 are queued and 1 is in flight. After releasing out_ready, all 5 accepted results return in tag order.
- Assert rst during RUN of 0x41100000 → out_valid=0, eng_rst=1 the same cycle, FIFO empty; a new request of 0x41800000 returns 0x40800000.
- With SQRT_TIMEOUT_EN and TIMEOUT_CYCLES=16, the engine never raises eng_rdy → after 16 RUN cycles, out_sqrt=0x7FC00000 and out_err=1; the next request completes normally.
